// File: rtl/alu_exec_if.sv
// Request/response bundle between ID/EX and the execute-stage ALU.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_exec_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               zero;
  logic [3:0]         op_code;
  logic               illegal;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, op_code, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, op_code, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, runs single-cycle ops or a
// WIDTH-cycle shift-add multiply, and holds the result under backpressure.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_ILL = 4'b1111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [3:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic             ovld_q, ovld_d;

  logic [3:0]       fn;
  logic [3:0]       dec_op;
  logic             dec_ill;
  logic [WIDTH-1:0] alu_res;
  logic             accept;

  assign fn = bus.funct[3:0];
  // Upper funct bits carry no meaning for this decoder.
  logic unused_funct;
  assign unused_funct = &{1'b0, bus.funct[FUNCT_W-1:4]};

  assign bus.in_ready  = !rst && (state_q == IDLE) && (!ovld_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = ovld_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.op_code   = op_q;
  assign bus.illegal   = ill_q;

  always_comb begin
    dec_op  = OP_ILL;
    dec_ill = 1'b1;
    case (bus.alu_op)
      2'b00: begin dec_op = OP_ADD; dec_ill = 1'b0; end
      2'b01: begin dec_op = OP_SUB; dec_ill = 1'b0; end
      2'b10: begin
        dec_ill = 1'b0;
        case (fn)
          4'b0000: dec_op = OP_ADD;
          4'b0010: dec_op = OP_SUB;
          4'b0100: dec_op = OP_AND;
          4'b0101: dec_op = OP_OR;
          4'b0111: dec_op = OP_NOR;
          4'b1010: dec_op = OP_SLT;
          4'b1000: dec_op = OP_MUL;
          default: begin dec_op = OP_ILL; dec_ill = 1'b1; end
        endcase
      end
      default: begin dec_op = OP_ILL; dec_ill = 1'b1; end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_d    = res_q;
    zero_d   = zero_q;
    op_d     = op_q;
    ill_d    = ill_q;
    ovld_d   = ovld_q;
    if (ovld_q && bus.out_ready) ovld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_op == OP_MUL) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            op_d   = dec_op;
            ill_d  = dec_ill;
            ovld_d = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration commits the accumulator including this cycle's add.
        if (cnt_q == CW'(WIDTH-1)) begin
          res_d   = acc_d;
          zero_d  = (acc_d == '0);
          op_d    = OP_MUL;
          ill_d   = 1'b0;
          ovld_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      zero_q   <= 1'b1;
      op_q     <= 4'b0000;
      ill_q    <= 1'b0;
      ovld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      op_q     <= op_d;
      ill_q    <= ill_d;
      ovld_q   <= ovld_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode, arithmetic, mul latency,
// illegal funct, backpressure and reset abandonment.
module tb_alu_exec_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_exec_if #(.WIDTH(32), .FUNCT_W(6)) bus();

  alu_exec_unit #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.a        = av;
    bus.b        = bv;
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r, input logic [3:0] op,
                         input logic z, input logic il);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".op"}, 32'(bus.op_code), 32'(op));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(il));
  endtask

  initial begin
    int cnt;
    int rdy_busy;
    int vld_seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_op = 2'b00;
    bus.funct = '0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;

    tick();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result", bus.result, 32'd0);
    chk("rst.zero", 32'(bus.zero), 32'd1);
    chk("rst.op", 32'(bus.op_code), 32'd0);
    chk("rst.illegal", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // add
    bus.out_ready = 1'b1;
    set_req(2'b00, 6'd0, 32'd5, 32'd7);
    tick();
    chk_res("add", 32'd12, 4'b0010, 1'b0, 1'b0);

    // back-to-back R-type ops
    set_req(2'b10, 6'b000010, 32'd3, 32'd3);
    tick();
    chk_res("sub", 32'd0, 4'b0110, 1'b1, 1'b0);
    set_req(2'b10, 6'b000100, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_res("and", 32'd1, 4'b0000, 1'b0, 1'b0);
    set_req(2'b10, 6'b000101, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_res("or", 32'hFFFF_FFFF, 4'b0001, 1'b0, 1'b0);
    set_req(2'b10, 6'b000111, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_res("nor", 32'd0, 4'b1100, 1'b1, 1'b0);
    set_req(2'b10, 6'b001010, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_res("slt", 32'd1, 4'b0111, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // mul: count edges from the accept edge (inclusive) to out_valid
    set_req(2'b10, 6'b001000, 32'h0001_0001, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    cnt = 1;
    rdy_busy = 0;
    while (!bus.out_valid && cnt < 100) begin
      if (bus.in_ready) rdy_busy++;
      tick();
      cnt++;
    end
    chk("mul.latency", 32'(cnt), 32'd33);
    chk("mul.in_ready_busy", 32'(rdy_busy), 32'd0);
    chk_res("mul", 32'h0003_0003, 4'b1000, 1'b0, 1'b0);
    tick();

    // illegal funct under R-type and alu_op 11
    set_req(2'b10, 6'b001111, 32'd5, 32'd5);
    tick();
    chk_res("ill10", 32'd0, 4'b1111, 1'b1, 1'b1);
    set_req(2'b00, 6'd0, 32'd1, 32'd1);
    tick();
    chk_res("add2", 32'd2, 4'b0010, 1'b0, 1'b0);
    set_req(2'b11, 6'd0, 32'd9, 32'd4);
    tick();
    chk_res("ill11", 32'd0, 4'b1111, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    tick();

    // backpressure: result holds, next request waits
    bus.out_ready = 1'b0;
    set_req(2'b00, 6'd0, 32'd10, 32'd20);
    tick();
    chk_res("bp", 32'd30, 4'b0010, 1'b0, 1'b0);
    set_req(2'b01, 6'd0, 32'd50, 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("bp.hold", bus.result, 32'd30);
      chk("bp.valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk_res("bp.swap", 32'd42, 4'b0110, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.drain", 32'(bus.out_valid), 32'd0);

    // reset in the middle of a multiply
    set_req(2'b10, 6'b001000, 32'd7, 32'd9);
    tick();
    bus.in_valid = 1'b0;
    vld_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.out_valid) vld_seen++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid) vld_seen++;
    end
    chk("rstmul.no_valid", 32'(vld_seen), 32'd0);
    chk("rstmul.result", bus.result, 32'd0);
    set_req(2'b00, 6'd0, 32'd1, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk_res("rstmul.add", 32'd2, 4'b0010, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised successor to the combinational ALU control decoder: it decodes ALUOp/funct into a 4-bit operation code and executes that operation on registered operands behind a valid/ready handshake. It adds an iterative multiply that takes WIDTH cycles, a NOR operation, and illegal-funct detection. It sits in the execute stage between the ID/EX pipeline register and the EX/MEM register.

## Interface
- WIDTH, 32, operand/result width (≥4)
- FUNCT_W, 6, funct field width; only funct[3:0] is decoded
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  2  ALUOp from main control
- funct  in  FUNCT_W  instruction funct field
- a, b  in  WIDTH  operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- op_code  out  4  decoded operation for the held result
- illegal  out  1  held result came from an undecodable funct

## Operation
- Decode, applied at accept:
  - alu_op 00 → 0010 (add)
  - alu_op 01 → 0110 (sub)
  - alu_op 10 decodes funct[3:0]: 0000→0010 add, 0010→0110 sub, 0100→0000 and, 0101→0001 or, 0111→1100 nor, 1010→0111 slt, 1000→1000 mul
  - Any other funct[3:0] under alu_op 10, and all of alu_op 11, → 1111 with illegal=1 and result=0.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - slt is signed two's-complement and returns 1 or 0 zero-extended.
  - mul returns the low WIDTH bits of the unsigned product.
- State machine has two states, IDLE and BUSY.
  - IDLE, accept, non-mul: compute and register result, op_code, illegal and zero; set out_valid; stay in IDLE.
  - IDLE, accept, mul: latch a and b; clear accumulator and counter cnt; go to BUSY.
  - BUSY: each cycle, if multiplier LSB is 1, add the shifted multiplicand to the accumulator; then shift the multiplicand left and the multiplier right, and increment cnt.
  - BUSY, on the edge where cnt == WIDTH-1: write the accumulator result, set out_valid, return to IDLE.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output transfer occurs when out_valid && out_ready; out_valid clears unless a new accept happens in the same cycle.
  - While out_valid=1 and out_ready=0, result, zero, op_code and illegal hold stable.
- Inputs are ignored while in_ready=0. The caller must hold inputs stable until accepted.

## Timing
- Reset values:
  - out_valid=0, in_ready=0 during the reset cycle, result=0, zero=1, op_code=0000, illegal=0
  - state=IDLE, cnt=0
- in_ready can rise in the first cycle after rst deasserts.
- Non-mul latency is 1: accept at edge k, out_valid high after edge k.
- Back-to-back non-mul with out_ready held high: one result per cycle.
- Mul latency is WIDTH+1 edges from accept to out_valid (1 load edge + WIDTH iteration edges). in_ready=0 for the whole BUSY period.
- Accept and output transfer in the same cycle: new result replaces old and out_valid stays 1.
- rst mid-BUSY: operation abandoned; state IDLE, out_valid 0, no result produced.
- rst while out_valid=1: the pending result is dropped.
- zero is computed from the final registered result, including mul and illegal.

## Test plan
- Reset, then alu_op=00, a=5, b=7, out_ready=1 → one cycle later result=12, op_code=0010, zero=0, illegal=0.
- alu_op=10, funct[3:0] applied back-to-back as 0010 (a=3, b=3), 0100, 0101, 0111, 1010 with a=0xFFFFFFFF, b=1:
  - sub → result=0, zero=1
  - and, or, nor → correct values
  - slt → result=1 (−1<1), op_code=0111
- mul with a=0x00010001, b=3 → out_valid exactly 33 edges after accept, result=0x00030003, op_code=1000; in_ready=0 throughout BUSY.
- alu_op=10, funct=6'b001111 → op_code=1111, illegal=1, result=0, zero=1. alu_op=11 gives the same response.
- Backpressure: out_ready=0 for 5 cycles after a result → result holds, in_ready=0, the next request waits. Raise out_ready with in_valid=1 → transfer and accept occur on the same edge, out_valid stays 1.
- Start mul, assert rst at BUSY cycle 10 → out_valid never rises. After reset, alu_op=00, a=1, b=1 → result=2 one cycle after accept.
